// File: rtl/cla_seq_arbiter.sv
// cla_seq_arbiter: two-requester arbiter sharing one 4-bit CLA slice, adding NIBBLES nibbles LSB first.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output rsp_ovf.
module cla_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIBBLES-1:0] rsp_sum,
`ifdef CLA_SEQ_OVF_EN
    output logic                 rsp_ovf,
`endif
    output logic                 rsp_cout
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t       state, state_nx;
    logic [W-1:0] a_r, b_r;
    logic [3:0]   cnt, na, nb, g, p, s;
    logic [5:0]   sh;
    logic         carry, id, last_grant, gnt, xfer, last, c1, c2, c3, c4;

    always_comb begin
        gnt  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        xfer = (state == IDLE) && (req0_valid || req1_valid);
        last = cnt == 4'(NIBBLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = xfer ? ADD : IDLE;
            ADD:     state_nx = last ? DONE : ADD;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = xfer & ~gnt;
        req1_ready = xfer & gnt;
        rsp_valid  = state == DONE;
        rsp_id     = id;
        rsp_cout   = carry;
    end

    // Current nibble is picked by shifting so any NIBBLES needs no index-width juggling
    always_comb begin
        sh = {cnt, 2'b00};
        na = 4'(a_r >> sh);
        nb = 4'(b_r >> sh);
        g  = na & nb;
        p  = na ^ nb;
        c1 = g[0] | (p[0] & carry);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry);
        s  = p ^ {c3, c2, c1, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            rsp_sum    <= '0;
        end else if (xfer) begin
            a_r        <= gnt ? req1_a : req0_a;
            b_r        <= gnt ? req1_b : req0_b;
            carry      <= gnt ? req1_cin : req0_cin;
            id         <= gnt;
            last_grant <= gnt;
            cnt        <= '0;
        end else if (state == ADD) begin
            rsp_sum <= (rsp_sum & ~(W'(4'hF) << sh)) | (W'(s) << sh);
            carry   <= c4;
            cnt     <= cnt + 4'd1;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rsp_ovf <= 1'b0;
        else if (state == ADD && last) rsp_ovf <= c3 ^ c4;
    end
`endif
endmodule

// File: doc/cla_seq_arbiter.md
# cla_seq_arbiter

Sequencing controller that shares a single 4-bit carry-lookahead adder slice between two requesters and uses it iteratively to perform multi-nibble additions. Each accepted request is added one nibble per cycle, LSB nibble first, with the slice carry registered between passes. The block sits between two operand producers and one result consumer. It is the team's standard way to reuse the narrow CLA datapath for wide adds without replicating it.

## Interface
Parameters:
- NIBBLES, 4: number of 4-bit passes per add; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index of the result
- rsp_sum  out  W  a + b + cin, modulo 2^W
- rsp_cout  out  1  carry out of MSB nibble
- rsp_ovf  out  1  signed overflow; present only with CLA_SEQ_OVF_EN

## Operation
- Internal datapath: one combinational 4-bit CLA slice with carry-in. g = a&b, p = a^b, c1..c4 in lookahead form from cin; sum = p ^ {c3,c2,c1,cin}.
- States: IDLE, ADD, DONE.
- IDLE: arbitration is evaluated combinationally.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - The granted reqN_ready is high this cycle; the other ready is low. A transfer occurs when valid&ready.
  - On transfer: latch a, b, cin into the carry register and the id; nibble counter <= 0; last_grant <= id; go to ADD.
- ADD: the slice adds nibble[cnt] of a and b with the carry register.
  - Write the slice sum into rsp_sum nibble cnt; carry <= c4; cnt++.
  - When cnt == NIBBLES-1, go to DONE after this pass.
- DONE: rsp_valid = 1 and rsp_sum/rsp_cout/rsp_id stay stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Both readys are low outside IDLE; requests held during ADD/DONE wait. Requesters must not make valid depend on ready.
- rsp_cout = final carry register value.
- Reset (asserted at any time, including mid-ADD or DONE):
  - State IDLE, cnt 0, carry 0, last_grant 1 (requester 0 wins the first tie).
  - rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, rsp_ovf 0.
  - Any in-flight operation is discarded; no response is produced for it.

## Timing
- The accept edge is T. rsp_valid is first high after edge T+NIBBLES.
- Minimum occupancy is NIBBLES+2 cycles per operation: 1 accept, NIBBLES add, at least 1 DONE.
- The earliest next accept is the cycle after the response handshake. There is no accept in the same cycle as the response handshake.
- ready is combinational from state and the valids. No combinational path exists from any input to rsp_*.
- With NIBBLES=1: one ADD cycle, then DONE.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - Port rsp_ovf exists.
  - During the last ADD pass, ovf <= c3 ^ c4 of the slice, i.e. carry into the MSB xor carry out of the MSB.
  - ovf is held in DONE and cleared on reset.
- Not defined: the rsp_ovf port and its register are absent. All other behaviour is identical.

## Test plan
- Single add, NIBBLES=4: req0 a=16'h00FF, b=16'h0001, cin=0 -> rsp_valid 4 cycles after accept, rsp_sum=16'h0100, rsp_cout=0, rsp_id=0.
- Full carry ripple: req1 a=16'hFFFF, b=16'h0000, cin=1 -> rsp_sum=16'h0000, rsp_cout=1, rsp_id=1. With the macro, rsp_ovf=0.
- Tie and fairness: both valid continuously with distinct operands, rsp_ready=1 -> grants alternate 0,1,0,1, starting with 0 after reset. Each operation takes 6 cycles.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> rsp_* stable, both readys low. Release -> one handshake, then IDLE.
- Reset mid-operation: deassert rst_n in the second ADD cycle -> all outputs 0 immediately. After release, no stale response appears, and a fresh req0 completes correctly.
- Signed overflow (macro on): a=16'h7FFF, b=16'h0001 -> rsp_sum=16'h8000, rsp_ovf=1, rsp_cout=0.
